// File: rtl/sound_mix_pkg.sv
// Shared constants, state encoding and helpers for the sample mix sequencer.
package sound_mix_pkg;

  localparam int NCH        = 8;
  localparam int CH_BEEP    = 0;
  localparam int CH_AYA     = 1;
  localparam int CH_AYB     = 2;
  localparam int CH_AYC     = 3;
  localparam int CH_RSA     = 4;
  localparam int CH_RSB     = 5;
  localparam int CH_RSC     = 6;
  localparam int CH_COVOX   = 7;

  localparam int GAIN_W     = 5;
  localparam int UNITY_GAIN = 16;
  localparam int BEEP_SCALE = 51;
  localparam int LEVEL_W    = 8;
  localparam int ACC_W      = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_ACC   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Beeper level: p0+p1+p2+2*p3 (0..5) scaled by 51 so the full range is 0..255.
  function automatic logic [LEVEL_W-1:0] beep_level(input logic [3:0] p);
    logic [LEVEL_W-1:0] s;
    s = LEVEL_W'(p[0]) + LEVEL_W'(p[1]) + LEVEL_W'(p[2]) + {{(LEVEL_W-2){1'b0}}, p[3], 1'b0};
    return LEVEL_W'(s * LEVEL_W'(BEEP_SCALE));
  endfunction

endpackage

// File: rtl/sound_mix_mac.sv
// Level x gain multiplier feeding a 15-bit accumulator; cleared and stepped by the sequencer.
module sound_mix_mac #(
  parameter int GAIN_W = 5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clr_i,
  input  logic                                   en_i,
  input  logic [sound_mix_pkg::LEVEL_W-1:0]      level_i,
  input  logic [GAIN_W-1:0]                      gain_i,
  output logic [sound_mix_pkg::ACC_W-1:0]        acc_next_o
);
  import sound_mix_pkg::*;

  localparam int PROD_W = LEVEL_W + GAIN_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q, acc_d;

  // Product and next accumulator value; the worst case 8*255*16 fits without wrap.
  always_comb begin
    prod = PROD_W'(level_i) * PROD_W'(gain_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  assign acc_next_o = acc_d;

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sound_mix_sequencer.sv
// Time-shared audio mixer: snapshots eight sources per sample strobe and
// accumulates level*gain one channel per clock through a single MAC.
module sound_mix_sequencer #(
  parameter int GAIN_W       = sound_mix_pkg::GAIN_W,
  parameter int DEFAULT_GAIN = 16
) (
  input  logic              clk24,
  input  logic              reset_n,
  input  logic              sample_ce,
  input  logic [3:0]        pulses,
  input  logic [7:0]        ay_soundA,
  input  logic [7:0]        ay_soundB,
  input  logic [7:0]        ay_soundC,
  input  logic [7:0]        rs_soundA,
  input  logic [7:0]        rs_soundB,
  input  logic [7:0]        rs_soundC,
  input  logic [7:0]        covox,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [GAIN_W-1:0] cfg_data,
  input  logic              ovr_clr,
  output logic [15:0]       mixed,
  output logic              mixed_valid,
  output logic              busy,
  output logic              overrun
);
  import sound_mix_pkg::*;

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
    if (int'(g) > UNITY_GAIN) return GAIN_W'(UNITY_GAIN);
    return g;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          ch_q, ch_d;
  logic [LEVEL_W-1:0]  lvl_q    [NCH];
  logic [LEVEL_W-1:0]  lvl_snap [NCH];
  logic [GAIN_W-1:0]   gain_q   [NCH];
  logic [GAIN_W-1:0]   shadow_q [NCH];
  logic [GAIN_W-1:0]   gain_wr_d;
  logic [15:0]         mixed_q, mixed_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;
  logic                latch_en, mac_clr, mac_en, load_out, ovr_evt;
  logic [ACC_W-1:0]    acc_next;

  // State register.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Sequencer next state and datapath controls: IDLE -> LATCH -> ACC x8 -> OUT.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    latch_en = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_ce) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en = 1'b1;
        mac_clr  = 1'b1;
        ch_d     = '0;
        state_d  = ST_ACC;
      end
      ST_ACC: begin
        mac_en = 1'b1;
        ch_d   = ch_q + 3'd1;
        if (ch_q == 3'(NCH - 1)) begin
          // Final sum is captured on this edge so it is visible during OUT.
          load_out = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel map of the live source levels.
  always_comb begin
    lvl_snap[CH_BEEP]  = beep_level(pulses);
    lvl_snap[CH_AYA]   = ay_soundA;
    lvl_snap[CH_AYB]   = ay_soundB;
    lvl_snap[CH_AYC]   = ay_soundC;
    lvl_snap[CH_RSA]   = rs_soundA;
    lvl_snap[CH_RSB]   = rs_soundB;
    lvl_snap[CH_RSC]   = rs_soundC;
    lvl_snap[CH_COVOX] = covox;
  end

  // Level snapshot, taken only in LATCH so source changes mid-sum are ignored.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) lvl_q[i] <= '0;
    end else if (latch_en) begin
      for (int i = 0; i < NCH; i++) lvl_q[i] <= lvl_snap[i];
    end
  end

  assign gain_wr_d = clamp_gain(cfg_data);

  // CPU gain registers (written any time) and shadow copies (refreshed in LATCH).
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        gain_q[i]   <= clamp_gain(GAIN_W'(DEFAULT_GAIN));
        shadow_q[i] <= clamp_gain(GAIN_W'(DEFAULT_GAIN));
      end
    end else begin
      if (latch_en) begin
        for (int i = 0; i < NCH; i++) shadow_q[i] <= gain_q[i];
      end
      if (cfg_we) gain_q[cfg_addr] <= gain_wr_d;
    end
  end

  sound_mix_mac #(
    .GAIN_W (GAIN_W)
  ) u_mac (
    .clk_i      (clk24),
    .rst_ni     (reset_n),
    .clr_i      (mac_clr),
    .en_i       (mac_en),
    .level_i    (lvl_q[ch_q]),
    .gain_i     (shadow_q[ch_q]),
    .acc_next_o (acc_next)
  );

  // Output and overrun next values; a new overrun event beats a clear.
  always_comb begin
    ovr_evt   = sample_ce && (state_q != ST_IDLE);
    mixed_d   = load_out ? {acc_next[ACC_W-1:0], 1'b0} : mixed_q;
    valid_d   = load_out;
    overrun_d = overrun_q;
    if (ovr_evt)      overrun_d = 1'b1;
    else if (ovr_clr) overrun_d = 1'b0;
  end

  // Held mix sample, valid pulse and sticky overrun flag.
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      mixed_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mixed_q   <= mixed_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign mixed       = mixed_q;
  assign mixed_valid = valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sound_mix_sequencer.sv
// Scoreboard bench for sound_mix_sequencer: stimulus pushes expected mixes,
// a monitor pops and compares whenever mixed_valid is seen.
module tb_sound_mix_sequencer;

  logic        clk24 = 1'b0;
  logic        reset_n;
  logic        sample_ce;
  logic [3:0]  pulses;
  logic [7:0]  ay_a, ay_b, ay_c, rs_a, rs_b, rs_c, cov;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [4:0]  cfg_data;
  logic        ovr_clr;
  logic [15:0] mixed;
  logic        mixed_valid, busy, overrun;

  sound_mix_sequencer #(.GAIN_W(5), .DEFAULT_GAIN(16)) dut (
    .clk24       (clk24),
    .reset_n     (reset_n),
    .sample_ce   (sample_ce),
    .pulses      (pulses),
    .ay_soundA   (ay_a),
    .ay_soundB   (ay_b),
    .ay_soundC   (ay_c),
    .rs_soundA   (rs_a),
    .rs_soundB   (rs_b),
    .rs_soundC   (rs_c),
    .covox       (cov),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ovr_clr     (ovr_clr),
    .mixed       (mixed),
    .mixed_valid (mixed_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #21 clk24 = ~clk24;

  int cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    int          when;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  int model_gain[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference mix: sum of level*gain over the eight channels, doubled, 16 bits.
  function automatic int model_mix();
    int lv[8];
    int sum;
    lv[0] = (int'(pulses[0]) + int'(pulses[1]) + int'(pulses[2]) + 2 * int'(pulses[3])) * 51;
    lv[1] = ay_a; lv[2] = ay_b; lv[3] = ay_c;
    lv[4] = rs_a; lv[5] = rs_b; lv[6] = rs_c; lv[7] = cov;
    sum = 0;
    for (int i = 0; i < 8; i++) sum += lv[i] * model_gain[i];
    return (sum * 2) & 32'h0000_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic set_levels(input logic [3:0] p, input logic [7:0] a, b, c, ra, rb, rc, cv);
    pulses = p; ay_a = a; ay_b = b; ay_c = c;
    rs_a = ra; rs_b = rb; rs_c = rc; cov = cv;
  endtask

  task automatic strobe(input int v);
    exp_t e;
    e.val  = v[15:0];
    e.when = cyc + 10;
    sb.push_back(e);
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    if (busy || sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: timeout busy=%0d pending=%0d expected idle", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = a[2:0]; cfg_data = d[4:0];
    tick();
    cfg_we = 1'b0;
    model_gain[a] = (d > 16) ? 16 : d;
  endtask

  // Monitor: every mixed_valid must match the oldest pending expectation and its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk24);
      if (mixed_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: got mixed_valid=1 mixed=%0d expected no output", mixed);
        end else begin
          e = sb.pop_front();
          check("mixed", mixed, e.val);
          check("valid_cycle", cyc, e.when);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sample_ce = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ovr_clr = 1'b0;
    set_levels(4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) model_gain[i] = 16;
    #5;
    check("rst_mixed", mixed, 0);
    check("rst_valid", mixed_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single AY channel at full scale; busy spans T+1..T+10.
    set_levels(4'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    strobe(8160);
    check("busy_T1", busy, 1);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check("busy_run", busy, 1);
    end
    tick();
    check("busy_T11", busy, 0);
    check("valid_T11", mixed_valid, 0);
    check("mixed_hold", mixed, 8160);
    wait_done();

    // Beeper weighting.
    set_levels(4'b1000, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    strobe(3264);
    wait_done();
    pulses = 4'b1111;
    strobe(8160);
    wait_done();

    // Full scale on every channel, then all gains zero.
    set_levels(4'b1111, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    strobe(65280);
    wait_done();
    for (int a = 0; a < 8; a++) cfg_write(a, 0);
    strobe(0);
    wait_done();
    for (int a = 0; a < 8; a++) cfg_write(a, 16);

    // Gain write during ACC lands on the following sample; oversize writes clamp.
    set_levels(4'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd200);
    strobe(6400);
    tick();
    cfg_write(7, 8);
    wait_done();
    strobe(3200);
    wait_done();
    cfg_write(7, 31);
    strobe(6400);
    wait_done();

    // Overrun: second strobe at T+5 is dropped, flag sticky, clear, set-beats-clear.
    strobe(6400);
    repeat (4) tick();
    check("ovr_before", overrun, 0);
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    check("ovr_T6", overrun, 1);
    wait_done();
    repeat (15) tick();
    check("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    strobe(6400);
    tick();
    sample_ce = 1'b1; ovr_clr = 1'b1;
    tick();
    sample_ce = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    wait_done();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr2", overrun, 0);

    // Reset mid-sequence clears outputs and gains; next sample is normal.
    cfg_write(7, 4);
    strobe(1600);
    wait_done();
    strobe(9999);
    tick();
    sample_ce = 1'b1;
    tick();
    sample_ce = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_mixed", mixed, 0);
    check("mid_rst_valid", mixed_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    sb.delete();
    for (int i = 0; i < 8; i++) model_gain[i] = 16;
    tick();
    reset_n = 1'b1;
    tick();
    strobe(6400);
    wait_done();

    // Randomized samples against the reference model.
    for (int it = 0; it < 40; it++) begin
      set_levels(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) cfg_write($urandom_range(0, 7), $urandom_range(0, 31));
      strobe(model_mix());
      tick();
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 0) cfg_write($urandom_range(0, 7), $urandom_range(0, 31));
      set_levels(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      wait_done();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_mix_sequencer.md
Name: sound_mix_sequencer

Overview:
- Time-shared mix controller for the audio path.
- On each sample strobe it snapshots the eight sound sources: 8253 beeper, AY A/B/C, RS A/B/C and covox.
- It then uses one multiply-accumulate unit, one channel per clock, with a CPU-configurable gain per channel.
- Output is a held 16-bit mixed sample plus a valid pulse. It feeds the delta-sigma/PWM output stage in place of the fixed-weight mix.

Parameters:
- GAIN_W, 5, gain width per channel; gain range 0..16, where 16 = unity.
- DEFAULT_GAIN, 16, reset gain for all channels.

Ports:
- clk24  in  1  system clock, 24 MHz
- reset_n  in  1  asynchronous reset, active low
- sample_ce  in  1  one-clock sample strobe (e.g. 48 kHz)
- pulses  in  4  8253 channel outputs; bit 3 weighted x2
- ay_soundA, ay_soundB, ay_soundC  in  8 each  AY channel levels
- rs_soundA, rs_soundB, rs_soundC  in  8 each  second sound chip levels
- covox  in  8  covox DAC level
- cfg_we  in  1  gain register write strobe
- cfg_addr  in  3  channel index 0..7
- cfg_data  in  GAIN_W  gain value; values >16 are clamped to 16 on write
- ovr_clr  in  1  clears the overrun flag
- mixed  out  16  mixed sample, held between updates
- mixed_valid  out  1  one-clock pulse when mixed updates
- busy  out  1  high while the sequencer is not IDLE
- overrun  out  1  sticky; a sample_ce arrived while busy

Behaviour:
- Reset (asynchronous):
  - mixed=0, mixed_valid=0, busy=0, overrun=0.
  - Gain registers and shadow gains = DEFAULT_GAIN.
  - Accumulator=0, state=IDLE.
- Channel map:
  - 0 = beep, 1..3 = AY A..C, 4..6 = RS A..C, 7 = covox.
  - Beep level = beepsum*51, where beepsum = p0+p1+p2+2*p3 (range 0..5), giving an 8-bit result of 0..255.
- FSM: IDLE -> LATCH -> ACC -> OUT -> IDLE.
  - IDLE: waits for sample_ce.
  - LATCH (1 clock): snapshots all eight levels and copies the gain registers into the shadow gains. Clears the accumulator. Sets ch=0.
  - ACC (8 clocks): acc += level[ch]*shadow_gain[ch], ch increments each clock. Leaves after ch=7.
  - OUT (1 clock): mixed <= {acc[14:0],1'b0}, mixed_valid=1.
- Latency: sample_ce in cycle T gives LATCH in T+1, ACC in T+2..T+9, and mixed/valid in T+10. busy is high T+1..T+10.
- Width rules:
  - Product is 8x5 = 13 bits. Accumulator is 15 bits; maximum 8*255*16 = 32640, so no overflow and no saturation logic.
  - mixed bit 0 is always 0.
- sample_ce while busy: the strobe is dropped, overrun is set next clock, and the current mix is unaffected.
- sample_ce arriving in the same cycle as OUT also counts as busy and is dropped.
- cfg_we at any time writes the gain register immediately. Shadow gains change only in LATCH, so a write during ACC takes effect on the next sample.
- ovr_clr and a new overrun event in the same cycle: set wins.
- Inputs are sampled only in LATCH; changes during ACC are ignored.
- Reset mid-sequence returns to IDLE with all outputs cleared.

Decomposition:
- Package sound_mix_pkg:
  - channel index constants CH_BEEP..CH_COVOX, NCH=8.
  - GAIN_W, UNITY_GAIN=16.
  - FSM state encoding.
  - beep-to-level scale constant 51.
- One sub-module, sound_mix_mac: 8-bit x GAIN_W multiplier with a 15-bit accumulator. It has clear and enable controls and is driven by the sequencer.

Test Plan:
- All gains at default, ay_soundA=255, all other inputs 0, one sample_ce -> mixed=8160 (4080<<1) exactly 10 clocks later, mixed_valid high for 1 clock.
- pulses=4'b1000, all gains 16 -> beep level 102, acc 1632, mixed=3264; pulses=4'b1111 -> mixed=8160.
- All inputs 255, all gains 16 -> mixed=65280. Then write gain 0 to every channel -> next sample gives mixed=0.
- Write cfg_addr=7, cfg_data=8 during ACC with covox=200 -> the current sample uses gain 16 (mixed=6400); the next sample uses gain 8 (mixed=3200). Write cfg_data=31 -> the gain reads as clamped 16.
- Assert sample_ce at T and again at T+5 -> one mixed_valid at T+10, overrun=1 from T+6 and sticky. Pulse ovr_clr -> overrun=0. ovr_clr coincident with a dropped strobe -> overrun stays 1.
- Assert reset_n low at T+6 of a sequence -> outputs cleared immediately, busy=0. After release, a new sample_ce gives the normal 10-clock result.
